// File: rtl/day1_cmd_sequencer_if.sv
// Byte-in / command-word-out handshake bundle for day1_cmd_sequencer.
// master: stream source plus downstream sink (testbench side); slave: the sequencer.
interface day1_cmd_sequencer_if;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    modport master (
        output in_valid, in_byte, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_byte, in_last, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/day1_cmd_sequencer.sv
// Parses ASCII "L<digits>\n" / "R<digits>\n" commands, one byte per cycle, and
// issues each as a {op, value} word over valid/ready. Tracks command count,
// end of stream (done) and malformed input (err).
// Optional feature macro: DAY1_SEQ_SKIP_ZERO_EN -- zero-valued commands are
// not issued and are counted on skip_count instead.
module day1_cmd_sequencer #(
    parameter int VAL_W      = 24,
    parameter int MAX_DIGITS = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    day1_cmd_sequencer_if.slave bus,
    output logic [31:0]         cmd_count,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef DAY1_SEQ_SKIP_ZERO_EN
    ,
    output logic [31:0]         skip_count
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DIGITS = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic [2:0]       state, state_nx;
    logic [7:0]       op, op_nx;
    logic [VAL_W-1:0] value, value_nx, value_dig;
    logic [CNT_W-1:0] digits, digits_nx;
    logic             last_seen, last_nx;
    logic             accept, xfer, err_set, term;
    logic             is_digit, is_op, is_space;
`ifdef DAY1_SEQ_SKIP_ZERO_EN
    logic             skip;
`endif

    assign accept   = bus.in_valid & bus.in_ready;
    assign xfer     = bus.out_valid & bus.out_ready;
    assign is_digit = (bus.in_byte >= 8'h30) && (bus.in_byte <= 8'h39);
    assign is_op    = (bus.in_byte == 8'h4C) || (bus.in_byte == 8'h52);
    assign is_space = (bus.in_byte == 8'h0A) || (bus.in_byte == 8'h0D) || (bus.in_byte == 8'h20);

    // value*10 + digit as shifts; MAX_DIGITS is chosen so this never overflows VAL_W
    assign value_dig = (value << 3) + (value << 1) + VAL_W'(bus.in_byte[3:0]);

    // All handshake outputs decode the state register only, so in_ready has no
    // path from out_ready and an async reset drops out_valid immediately.
    assign bus.in_ready  = (state == S_IDLE) || (state == S_DIGITS) || (state == S_DRAIN);
    assign bus.out_valid = (state == S_ISSUE);
    assign bus.out_data  = {op, 24'(value)};
    assign busy          = (state != S_IDLE) && (state != S_DONE);
    assign done          = (state == S_DONE);

    // Next-state and datapath decode for the accepted byte
    always_comb begin
        state_nx  = state;
        op_nx     = op;
        value_nx  = value;
        digits_nx = digits;
        last_nx   = last_seen;
        err_set   = 1'b0;
        term      = 1'b0;
`ifdef DAY1_SEQ_SKIP_ZERO_EN
        skip      = 1'b0;
`endif
        case (state)
            S_IDLE: if (accept) begin
                if (is_op) begin
                    op_nx     = bus.in_byte;
                    value_nx  = '0;
                    digits_nx = '0;
                    state_nx  = S_DIGITS;
                end else if (!is_space) begin
                    err_set  = 1'b1;
                    state_nx = S_DRAIN;
                end
                // a final byte in IDLE ends the stream whatever it was
                if (bus.in_last) state_nx = S_DONE;
            end
            S_DIGITS: if (accept) begin
                if (is_digit) begin
                    if (digits == CNT_W'(MAX_DIGITS)) begin
                        err_set = 1'b1;
                    end else begin
                        value_nx  = value_dig;
                        digits_nx = digits + 1'b1;
                        term      = bus.in_last;
                    end
                end else if (bus.in_byte == 8'h0D) begin
                    // CR is transparent unless it is the very last byte
                    if (bus.in_last) begin
                        if (digits != '0) term = 1'b1;
                        else              err_set = 1'b1;
                    end
                end else if (bus.in_byte == 8'h0A && digits != '0) begin
                    term = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
                if (err_set) state_nx = bus.in_last ? S_DONE : S_DRAIN;
                if (term) begin
                    last_nx  = bus.in_last;
                    state_nx = S_ISSUE;
`ifdef DAY1_SEQ_SKIP_ZERO_EN
                    if (value_nx == '0) begin
                        skip     = 1'b1;
                        state_nx = bus.in_last ? S_DONE : S_IDLE;
                    end
`endif
                end
            end
            S_ISSUE:  if (bus.out_ready) state_nx = last_seen ? S_DONE : S_IDLE;
            S_DRAIN:  if (accept && bus.in_last) state_nx = S_DONE;
            S_DONE:   state_nx = S_DONE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // State and command registers; clear wins over every transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op        <= '0;
            value     <= '0;
            digits    <= '0;
            last_seen <= 1'b0;
        end else if (clear) begin
            state     <= S_IDLE;
            op        <= '0;
            value     <= '0;
            digits    <= '0;
            last_seen <= 1'b0;
        end else begin
            state     <= state_nx;
            op        <= op_nx;
            value     <= value_nx;
            digits    <= digits_nx;
            last_seen <= last_nx;
        end
    end

    // Sticky error flag and transfer counter; a word dropped by clear is not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_count <= '0;
            err       <= 1'b0;
        end else if (clear) begin
            cmd_count <= '0;
            err       <= 1'b0;
        end else begin
            if (xfer) cmd_count <= cmd_count + 32'd1;
            if (err_set) err <= 1'b1;
        end
    end

`ifdef DAY1_SEQ_SKIP_ZERO_EN
    // Counts zero-valued commands that were swallowed instead of issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      skip_count <= '0;
        else if (clear)  skip_count <= '0;
        else if (skip)   skip_count <= skip_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_day1_cmd_sequencer.sv
// Bench for day1_cmd_sequencer: vector table, hand-written corner sequences and
// randomized streams checked against a scanning reference model.
module tb_day1_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] cmd_count;
    logic        busy, done, err;
`ifdef DAY1_SEQ_SKIP_ZERO_EN
    logic [31:0] skip_count;
`endif

    day1_cmd_sequencer_if bus ();

    day1_cmd_sequencer #(.VAL_W(24), .MAX_DIGITS(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .bus       (bus.slave),
        .cmd_count (cmd_count),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef DAY1_SEQ_SKIP_ZERO_EN
        ,
        .skip_count(skip_count)
`endif
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Beat collector and hold-stability checker, sampled on the falling edge
    logic [31:0] got[$];
    logic        hold = 1'b0;
    logic [31:0] hold_data = '0;
    always @(negedge clk) begin
        if (rst_n && !clear && hold) begin
            chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_data", bus.out_data, hold_data);
        end
        if (rst_n && !clear && bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
        hold      <= rst_n && !clear && bus.out_valid && !bus.out_ready;
        hold_data <= bus.out_data;
    end

    bit rnd_rdy = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic put_byte(input logic [7:0] b, input bit last);
        bit acc;
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        bus.in_last  = last;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            t++;
        end while (!acc && t < 100);
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last);
        for (int i = 0; i < s.len(); i++) put_byte(s[i], last && (i == s.len() - 1));
    endtask

    logic [7:0] stim[$];
    task automatic send_q();
        for (int i = 0; i < stim.size(); i++) put_byte(stim[i], i == stim.size() - 1);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (t < 300) begin
            @(negedge clk);
            if (done) break;
            tick();
            t++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        tick();
    endtask

    task automatic clr();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        got.delete();
    endtask

    // Reference model: scans the whole stream by index, command by command
    logic [31:0] exp_q[$];
    bit          exp_err;
    int          exp_skip;

    function automatic void emit(input logic [7:0] op, input int val);
`ifdef DAY1_SEQ_SKIP_ZERO_EN
        if (val == 0) begin
            exp_skip++;
            return;
        end
`endif
        exp_q.push_back({op, 24'(val)});
    endfunction

    function automatic void model();
        int n, i, nd, val;
        bit stop, cmd_end, lastb;
        logic [7:0] c, op;
        n = stim.size(); i = 0; stop = 0;
        exp_q.delete(); exp_err = 0; exp_skip = 0;
        while (i < n && !stop) begin
            c = stim[i];
            if (c == 8'h20 || c == 8'h0A || c == 8'h0D) begin
                i++;
            end else if (c != 8'h4C && c != 8'h52) begin
                exp_err = 1; stop = 1;
            end else begin
                op = c; i++; nd = 0; val = 0; cmd_end = 0;
                while (i < n && !cmd_end && !stop) begin
                    c = stim[i]; lastb = (i == n - 1); i++;
                    if (c >= 8'h30 && c <= 8'h39) begin
                        if (nd == 6) begin exp_err = 1; stop = 1; end
                        else begin
                            nd++; val = val * 10 + int'(c) - 48;
                            if (lastb) emit(op, val);
                        end
                    end else if (c == 8'h0D) begin
                        if (lastb) begin
                            if (nd > 0) emit(op, val);
                            else exp_err = 1;
                        end
                    end else if (c == 8'h0A && nd > 0) begin
                        emit(op, val); cmd_end = 1;
                    end else begin
                        exp_err = 1; stop = 1;
                    end
                end
            end
        end
    endfunction

    typedef struct {
        string       txt;
        int          beats;
        logic [31:0] first;
        logic [31:0] final_w;
        bit          e;
    } vec_t;
    vec_t tbl[$];

    initial begin
        bus.in_valid = 1'b0; bus.in_byte = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;

        tbl.push_back('{"R48\n", 1, 32'h52000030, 32'h52000030, 1'b0});
        tbl.push_back('{"L68\nL30\n", 2, 32'h4C000044, 32'h4C00001E, 1'b0});
        tbl.push_back('{"R1234567\nL5\n", 0, 32'h0, 32'h0, 1'b1});
        tbl.push_back('{"  \r\nR5\n", 1, 32'h52000005, 32'h52000005, 1'b0});
        tbl.push_back('{"X12\nR3\n", 0, 32'h0, 32'h0, 1'b1});
        tbl.push_back('{"L\n", 0, 32'h0, 32'h0, 1'b1});
        tbl.push_back('{"R999999\n", 1, 32'h520F423F, 32'h520F423F, 1'b0});
        tbl.push_back('{"L7\r\nL12", 2, 32'h4C000007, 32'h4C00000C, 1'b0});
`ifdef DAY1_SEQ_SKIP_ZERO_EN
        tbl.push_back('{"R0\n", 0, 32'h0, 32'h0, 1'b0});
`else
        tbl.push_back('{"R0\n", 1, 32'h52000000, 32'h52000000, 1'b0});
`endif

        // reset values while rst_n is low
        #12;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_cmd_count", cmd_count, 32'd0);
        chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        tick();

        // table vectors, final byte carries in_last, downstream always ready
        foreach (tbl[k]) begin
            clr();
            send_str(tbl[k].txt, 1'b1);
            wait_done();
            chk($sformatf("tbl%0d_beats", k), got.size(), tbl[k].beats);
            if (tbl[k].beats > 0 && got.size() > 0) begin
                chk($sformatf("tbl%0d_first", k), got[0], tbl[k].first);
                chk($sformatf("tbl%0d_final", k), got[got.size()-1], tbl[k].final_w);
            end
            chk($sformatf("tbl%0d_err", k), {31'd0, err}, {31'd0, tbl[k].e});
            chk($sformatf("tbl%0d_cmd_count", k), cmd_count, tbl[k].beats);
            chk($sformatf("tbl%0d_in_ready", k), {31'd0, bus.in_ready}, 32'd0);
        end
`ifdef DAY1_SEQ_SKIP_ZERO_EN
        chk("skip_count_r0", skip_count, 32'd1);
`endif

        // latency: out_valid the cycle after "\n", transfer next edge
        clr();
        send_str("R48\n", 1'b0);
        @(negedge clk);
        chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("lat_data", bus.out_data, 32'h52000030);
        chk("lat_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("lat_busy", {31'd0, busy}, 32'd1);
        tick();
        @(negedge clk);
        chk("lat_after_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("lat_cmd_count", cmd_count, 32'd1);
        chk("lat_after_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();

        // backpressure: out_ready low five cycles
        clr();
        bus.out_ready = 1'b0;
        send_str("R999\n", 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_data", bus.out_data, 32'h520003E7);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_cnt_before", cmd_count, 32'd0);
        tick();
        @(negedge clk);
        chk("bp_valid_after", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_cmd_count", cmd_count, 32'd1);
        tick();

        // async reset in the middle of ISSUE
        clr();
        bus.out_ready = 1'b0;
        send_str("L5\n", 1'b0);
        @(negedge clk);
        chk("rmid_valid", {31'd0, bus.out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        chk("rmid_data", bus.out_data, 32'd0);
        chk("rmid_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rmid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        tick();
        bus.out_ready = 1'b1;
        got.delete();
        send_str("R1\n", 1'b0);
        tick();
        @(negedge clk);
        chk("rmid_beats", got.size(), 32'd1);
        if (got.size() > 0) chk("rmid_word", got[0], 32'h52000001);
        chk("rmid_cmd_count", cmd_count, 32'd1);
        tick();

        // clear during ISSUE drops the word uncounted
        clr();
        bus.out_ready = 1'b0;
        send_str("R7\n", 1'b0);
        clear = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("clr_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("clr_cmd_count", cmd_count, 32'd0);
        chk("clr_beats", got.size(), 32'd0);
        chk("clr_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();

        // randomized streams with random downstream stalls
        rnd_rdy = 1'b1;
        for (int r = 0; r < 40; r++) begin
            int k, nd;
            stim.delete();
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) begin
                if ($urandom_range(0, 3) == 0) stim.push_back(8'h20);
                stim.push_back($urandom_range(0, 1) ? 8'h4C : 8'h52);
                nd = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(1, 4);
                for (int d = 0; d < nd; d++)
                    stim.push_back(($urandom_range(0, 3) == 0) ? 8'h30 : 8'(8'h30 + $urandom_range(0, 9)));
                if ($urandom_range(0, 3) == 0) stim.push_back(8'h0D);
                stim.push_back(8'h0A);
            end
            if ($urandom_range(0, 1) == 0) void'(stim.pop_back());
            if (stim[stim.size()-1] == 8'h0D) void'(stim.pop_back());
            if ($urandom_range(0, 7) == 0) stim[$urandom_range(0, stim.size()-1)] = 8'($urandom_range(33, 126));
            model();
            clr();
            send_q();
            wait_done();
            chk($sformatf("rnd%0d_beats", r), got.size(), exp_q.size());
            for (int j = 0; j < exp_q.size() && j < got.size(); j++)
                chk($sformatf("rnd%0d_word%0d", r, j), got[j], exp_q[j]);
            chk($sformatf("rnd%0d_err", r), {31'd0, err}, {31'd0, exp_err});
            chk($sformatf("rnd%0d_cmd_count", r), cmd_count, exp_q.size());
`ifdef DAY1_SEQ_SKIP_ZERO_EN
            chk($sformatf("rnd%0d_skip", r), skip_count, exp_skip);
`endif
        end
        rnd_rdy = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
